// File: rtl/viterbi_ctrl_seq_pkg.sv
// Shared definitions for the Viterbi control sequencer.
//   - seq_state_e : sequencer FSM states
//   - default traceback depth, counter width and stage-pipe depth
package viterbi_ctrl_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_TRACE = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  localparam int TB_DEPTH_DEF = 16;
  localparam int LEN_W_DEF    = 8;
  // ce -> s -> bm -> acs : four datapath stages ahead of survivor memory
  localparam int PIPE_DEPTH   = 4;

endpackage

// File: rtl/viterbi_stage_pipe.sv
// Stage-valid shift register with input feed counter.
// A token enters stage 0 for every decoder step still to be fed and walks
// one stage per advance, so stage i is valid exactly while step data sits
// in datapath stage i.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   i_adv        : global advance (registers hold when 0)
//   i_load       : accepted start of a non-empty frame
//   i_shift      : sequencer is running; shift the pipe this cycle
//   i_len        : frame length, captured on i_load
//   o_pipe       : current stage-valid vector
//   o_pipe_nxt   : value the pipe takes on the next shift
module viterbi_stage_pipe #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_adv,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [LEN_W-1:0] i_len,
  output logic [DEPTH-1:0] o_pipe,
  output logic [DEPTH-1:0] o_pipe_nxt
);

  logic [DEPTH-1:0] pipe_q, pipe_d;
  logic [LEN_W-1:0] in_cnt_q, in_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             feed;

  always_comb begin
    feed       = (in_cnt_q < len_q);
    o_pipe_nxt = {pipe_q[DEPTH-2:0], feed};
    pipe_d     = pipe_q;
    in_cnt_d   = in_cnt_q;
    len_d      = len_q;
    if (i_load) begin
      // The first step is fed in the same cycle the frame is accepted.
      len_d    = i_len;
      pipe_d   = DEPTH'(1);
      in_cnt_d = LEN_W'(1);
    end else if (i_shift) begin
      pipe_d = o_pipe_nxt;
      if (feed) in_cnt_d = in_cnt_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q   <= '0;
      in_cnt_q <= '0;
      len_q    <= '0;
    end else if (i_adv) begin
      pipe_q   <= pipe_d;
      in_cnt_q <= in_cnt_d;
      len_q    <= len_d;
    end
  end

  assign o_pipe = pipe_q;

endmodule

// File: rtl/viterbi_ctrl_seq.sv
// Frame sequencer for the Viterbi decoder datapath.
// Staggers the enables of codeword extract, select, branch metric, ACS,
// survivor memory and traceback so the pipeline fills and drains around a
// programmable-length frame, then flushes a TB_DEPTH traceback window.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   en              : global advance; 0 stalls and forces enables/done low
//   i_start         : start request, accepted only in IDLE with en=1
//   i_frame_len     : frame length in decoder steps, captured on start
//   o_en_ce/s/bm/acs/m/t : datapath stage enables
//   o_busy          : sequencer not idle
//   o_done          : one-cycle end-of-frame pulse
//   o_stage_cnt     : ACS steps completed in the current/last frame
module viterbi_ctrl_seq
  import viterbi_ctrl_seq_pkg::*;
#(
  parameter int TB_DEPTH = TB_DEPTH_DEF,
  parameter int LEN_W    = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_frame_len,
  output logic             o_en_ce,
  output logic             o_en_s,
  output logic             o_en_bm,
  output logic             o_en_acs,
  output logic             o_en_m,
  output logic             o_en_t,
  output logic             o_busy,
  output logic             o_done,
  output logic [LEN_W-1:0] o_stage_cnt
);

  localparam int TB_W = $clog2(TB_DEPTH + 1);
  localparam logic [TB_W-1:0] TB_LAST = TB_W'(TB_DEPTH - 1);

  seq_state_e            state_q, state_d;
  logic [LEN_W-1:0]      acs_cnt_q, acs_cnt_d;
  logic [TB_W-1:0]       tb_cnt_q, tb_cnt_d;
  logic [PIPE_DEPTH-1:0] pipe, pipe_nxt;
  logic                  start_ok, load, in_run, in_trace, win_full;

  assign start_ok = (state_q == ST_IDLE) && i_start;
  assign load     = start_ok && (i_frame_len != '0);
  assign in_run   = (state_q == ST_RUN);
  assign in_trace = (state_q == ST_TRACE);

  viterbi_stage_pipe #(
    .DEPTH (PIPE_DEPTH),
    .LEN_W (LEN_W)
  ) u_pipe (
    .clk        (clk),
    .rst        (rst),
    .i_adv      (en),
    .i_load     (load),
    .i_shift    (in_run),
    .i_len      (i_frame_len),
    .o_pipe     (pipe),
    .o_pipe_nxt (pipe_nxt)
  );

  always_comb begin
    state_d   = state_q;
    acs_cnt_d = acs_cnt_q;
    tb_cnt_d  = tb_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          acs_cnt_d = '0;
          // An empty frame skips the datapath entirely.
          state_d   = load ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (pipe[PIPE_DEPTH-1]) acs_cnt_d = acs_cnt_q + LEN_W'(1);
        if (pipe_nxt == '0) begin
          state_d  = ST_TRACE;
          tb_cnt_d = '0;
        end
      end
      ST_TRACE: begin
        tb_cnt_d = tb_cnt_q + TB_W'(1);
        if (tb_cnt_q == TB_LAST) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acs_cnt_q <= '0;
      tb_cnt_q  <= '0;
    end else if (en) begin
      state_q   <= state_d;
      acs_cnt_q <= acs_cnt_d;
      tb_cnt_q  <= tb_cnt_d;
    end
  end

  // Sliding-window traceback starts once a full window of ACS steps exists.
  assign win_full = (32'(acs_cnt_q) >= 32'(TB_DEPTH));

  assign o_en_ce     = en && in_run && pipe[0];
  assign o_en_s      = en && in_run && pipe[1];
  assign o_en_bm     = en && in_run && pipe[2];
  assign o_en_acs    = en && in_run && pipe[3];
  assign o_en_m      = en && ((in_run && pipe[3]) || in_trace);
  assign o_en_t      = en && ((in_run && pipe[3] && win_full) || in_trace);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = en && (state_q == ST_DONE);
  assign o_stage_cnt = acs_cnt_q;

endmodule

// File: doc/viterbi_ctrl_seq.md
Name: viterbi_ctrl_seq

Overview:
Frame-based sequencer for the Viterbi decoder datapath. It drives the enables of codeword extract (ce), select (s), branch metric (bm), add-compare-select (acs), survivor memory (m) and traceback (t). Enables are staggered to fill and drain the pipeline. Frame length and traceback depth are programmable, and a start/busy/done handshake is provided to the host. Replaces the fixed always-on enable controller.

Parameters:
TB_DEPTH, 16, traceback window depth in decoder steps (>=1)
LEN_W, 8, width of frame length and step counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
en  in  1  global advance; 0 = stall (state held, all enables forced 0)
i_start  in  1  start a frame; sampled only in IDLE with en=1
i_frame_len  in  LEN_W  frame length in decoder steps; latched on accepted start
o_en_ce  out  1  codeword extract enable
o_en_s  out  1  select enable
o_en_bm  out  1  branch metric enable
o_en_acs  out  1  ACS enable
o_en_m  out  1  survivor memory enable
o_en_t  out  1  traceback enable
o_busy  out  1  state != IDLE
o_done  out  1  one-cycle pulse at frame end
o_stage_cnt  out  LEN_W  ACS steps completed in current frame

Behaviour:
- rst=1: state=IDLE, pipe=0, counters=0, len_q=0. All outputs 0 immediately. Aborts any frame mid-operation; no o_done is produced.
- en=0: no register changes. All o_en_* and o_done are forced 0. o_busy and o_stage_cnt reflect held state.
- All register updates below occur only on edges with en=1.
- States: IDLE, RUN, TRACE, DONE.
- Internal registers: pipe[3:0] (stage valid shift register); in_cnt, acs_cnt (LEN_W each); tb_cnt ($clog2(TB_DEPTH+1) bits).
- IDLE -> RUN on i_start with i_frame_len!=0: len_q<=i_frame_len, pipe<=4'b0001, in_cnt<=1, acs_cnt<=0.
- IDLE -> DONE on i_start with i_frame_len==0. No datapath enables are asserted for that frame.
- i_start outside IDLE is ignored.
- RUN:
  - feed = (in_cnt < len_q); pipe <= {pipe[2:0], feed}; in_cnt increments when feed=1.
  - acs_cnt increments on each cycle with pipe[3]=1.
  - Transition to TRACE, with tb_cnt<=0, when the next pipe value is 0.
- Enable decode (combinational from registered state, gated by en):
  - In RUN: ce=pipe[0], s=pipe[1], bm=pipe[2], acs=pipe[3], m=pipe[3].
  - In RUN: t = pipe[3] && (acs_cnt >= TB_DEPTH), giving a sliding-window traceback.
- TRACE:
  - m=1, t=1, all other enables 0; tb_cnt increments each cycle.
  - After TB_DEPTH cycles (tb_cnt==TB_DEPTH-1) go to DONE.
  - Runs the full TB_DEPTH even if len_q < TB_DEPTH.
- DONE: o_done=1 for one cycle, all enables 0, then IDLE. o_stage_cnt holds its final value until the next accepted start.
- Timing for frame length N>0, start accepted at cycle 0:
  - ce on cycles 1..N; s on 2..N+1; bm on 3..N+2; acs/m on 4..N+3.
  - TRACE on cycles N+4..N+3+TB_DEPTH.
  - o_done at cycle N+4+TB_DEPTH; IDLE at N+5+TB_DEPTH.
  - Cycles are counted in en=1 cycles.
- Max N = 2^LEN_W-1. Counters never wrap within a frame.

Decomposition:
- Shared package (param_def): state enum type and the default TB_DEPTH and LEN_W constants.
- Optional sub-module viterbi_stage_pipe: the pipe shift register plus feed counter, with a generic depth parameter. Everything else lives in viterbi_ctrl_seq.

Test Plan:
- Reset then idle, rst pulsed asynchronously mid-cycle -> all outputs 0 immediately; o_busy=0; no enable ever asserted.
- N=20, TB_DEPTH=16, en=1 -> ce on cycles 1-20, acs on 4-23, o_en_t in RUN on 20-23, TRACE 24-39, o_done at cycle 40, o_stage_cnt=20.
- N=1 -> ce@1, s@2, bm@3, acs/m@4, t on 5-20, o_done@21; a second i_start during busy is ignored.
- N=0 -> o_busy for 1 cycle, o_done@1, all datapath enables 0.
- N=20 with en=0 for 3 cycles at cycle 10 -> enables 0 during the stall; the whole schedule shifts by 3 (o_done@43); pipe contents preserved across the stall.
- rst asserted at cycle 15 of an N=20 frame -> immediate return to IDLE, no o_done; a new start with N=5 afterwards completes with o_done at cycle 25 relative to its own start.
